// File: rtl/proj_pkg.sv
// Shared constants and types for the FM datapath. The fragment-memory ring
// pulls its default geometry and buffer-state encoding from here.
package proj_pkg;

  localparam int FM_DATA_BITS         = 2;
  localparam int SIGNED_INDICE_LEN    = 10;
  localparam int FM_ENTRIES           = 256;
  localparam int FM_RING_BUFFER_COUNT = 3;
  localparam int FM_WR_LANES          = 4;
  localparam int FM_FRAG_SYMS         = 32;

  // Life cycle of one ring buffer.
  typedef enum logic [1:0] {
    FM_FREE    = 2'd0,
    FM_FILLING = 2'd1,
    FM_FULL    = 2'd2
  } fm_buf_state_e;

endpackage

// File: rtl/proj_fm_frag_extract.sv
// Combinational signed-window extraction of FRAG_SYMS symbols from one buffer.
// Symbols whose index falls outside 0..ENTRIES-1 are returned as zero.
module proj_fm_frag_extract
  import proj_pkg::*;
#(
  parameter int ENTRIES           = FM_ENTRIES,
  parameter int DATA_BITS         = FM_DATA_BITS,
  parameter int FRAG_SYMS         = FM_FRAG_SYMS,
  parameter int SIGNED_INDICE_LEN = proj_pkg::SIGNED_INDICE_LEN
) (
  input  logic [ENTRIES*DATA_BITS-1:0]   buf_data,
  input  logic [SIGNED_INDICE_LEN-1:0]   frag_idx,
  output logic [FRAG_SYMS*DATA_BITS-1:0] frag_data
);

  localparam int AW = $clog2(ENTRIES);
  // One extra bit so idx + k never wraps.
  localparam int IW = SIGNED_INDICE_LEN + 1;
  localparam logic signed [IW-1:0] ENT_S = IW'(ENTRIES);

  logic signed [IW-1:0] w_base;
  logic [DATA_BITS-1:0] w_syms [ENTRIES];

  assign w_base = $signed({frag_idx[SIGNED_INDICE_LEN-1], frag_idx});

  // Unpacked symbol view of the flat buffer so lookups are a plain array index.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_view
      assign w_syms[gi] = buf_data[gi*DATA_BITS +: DATA_BITS];
    end
  endgenerate

  // One lane per output symbol: bounds check then select, zero when outside.
  generate
    for (genvar gi = 0; gi < FRAG_SYMS; gi++) begin : g_sym
      localparam logic signed [IW-1:0] K_OFF = IW'(gi);
      logic signed [IW-1:0] w_addr;
      logic                 w_in_range;
      assign w_addr     = w_base + K_OFF;
      assign w_in_range = !w_addr[IW-1] && (w_addr < ENT_S);
      assign frag_data[gi*DATA_BITS +: DATA_BITS] =
        w_in_range ? w_syms[w_addr[AW-1:0]] : '0;
    end
  endgenerate

endmodule

// File: rtl/proj_fm_ring.sv
// N-way ring of fragment-memory buffers. The producer fills buffers in ring
// order with multi-symbol beats; the consumer reads zero-padded fragments
// from the oldest full buffer and releases it explicitly when done.
module proj_fm_ring
  import proj_pkg::*;
#(
  parameter int BUFFER_COUNT      = FM_RING_BUFFER_COUNT,
  parameter int ENTRIES           = FM_ENTRIES,
  parameter int DATA_BITS         = FM_DATA_BITS,
  parameter int WR_LANES          = FM_WR_LANES,
  parameter int FRAG_SYMS         = FM_FRAG_SYMS,
  parameter int SIGNED_INDICE_LEN = proj_pkg::SIGNED_INDICE_LEN
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WR_LANES*DATA_BITS-1:0]        in_wdata,
  input  logic                                 rel_valid,
  input  logic                                 req_valid,
  input  logic [SIGNED_INDICE_LEN-1:0]         frag_idx,
  output logic                                 buf_avail,
  output logic                                 out_valid,
  output logic                                 out_err,
  output logic [FRAG_SYMS*DATA_BITS-1:0]       out_rdata,
  output logic [$clog2(BUFFER_COUNT+1)-1:0]    occupancy
);

  localparam int PTR_W  = $clog2(BUFFER_COUNT);
  localparam int BEATS  = ENTRIES / WR_LANES;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int OCC_W  = $clog2(BUFFER_COUNT + 1);
  localparam int BEAT_W = WR_LANES * DATA_BITS;
  localparam int BUF_W  = ENTRIES * DATA_BITS;
  localparam int FRAG_W = FRAG_SYMS * DATA_BITS;

  logic [BUF_W-1:0]  r_mem [BUFFER_COUNT];
  fm_buf_state_e     r_state [BUFFER_COUNT];
  fm_buf_state_e     w_state_next [BUFFER_COUNT];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [OCC_W-1:0]  r_occ;
  logic [FRAG_W-1:0] r_rdata;
  logic              r_out_valid;
  logic              r_out_err;

  logic              w_wr_fire;
  logic              w_wr_last;
  logic              w_rel_fire;
  logic              w_req_fire;
  logic [PTR_W-1:0]  w_wr_ptr_inc;
  logic [PTR_W-1:0]  w_rd_ptr_inc;
  logic [BUF_W-1:0]  w_rd_buf;
  logic [FRAG_W-1:0] w_frag;

  // Handshakes are derived from registered state only.
  assign in_ready   = (r_state[r_wr_ptr] != FM_FULL);
  assign buf_avail  = (r_occ != '0);
  assign w_wr_fire  = in_valid && in_ready;
  assign w_wr_last  = w_wr_fire && (r_cnt == CNT_W'(BEATS - 1));
  assign w_rel_fire = rel_valid && buf_avail;
  assign w_req_fire = req_valid && buf_avail;

  assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(BUFFER_COUNT - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_inc = (r_rd_ptr == PTR_W'(BUFFER_COUNT - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

  assign out_valid = r_out_valid;
  assign out_err   = r_out_err;
  assign out_rdata = r_rdata;
  assign occupancy = r_occ;

  // Buffer storage: one beat lands at the current beat slot of the fill buffer.
  // Contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_fire) begin
      r_mem[r_wr_ptr][r_cnt*BEAT_W +: BEAT_W] <= in_wdata;
    end
  end

  // Next state per buffer. A buffer can only be the write target while not
  // FULL and only be released while FULL, so the two never hit the same one.
  always_comb begin
    for (int b = 0; b < BUFFER_COUNT; b++) begin
      w_state_next[b] = r_state[b];
      if (r_state[b] == FM_FULL) begin
        if (w_rel_fire && (r_rd_ptr == PTR_W'(b))) begin
          w_state_next[b] = FM_FREE;
        end
      end else if (w_wr_fire && (r_wr_ptr == PTR_W'(b))) begin
        w_state_next[b] = w_wr_last ? FM_FULL : FM_FILLING;
      end
    end
  end

  // Buffer state register.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BUFFER_COUNT; b++) begin
      if (rst) begin
        r_state[b] <= FM_FREE;
      end else begin
        r_state[b] <= w_state_next[b];
      end
    end
  end

  // Ring pointers, beat counter and full-buffer count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_occ    <= '0;
    end else begin
      if (w_wr_fire) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_wr_last) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_rel_fire) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      case ({w_wr_last, w_rel_fire})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign w_rd_buf = r_mem[r_rd_ptr];

  proj_fm_frag_extract #(
    .ENTRIES           (ENTRIES),
    .DATA_BITS         (DATA_BITS),
    .FRAG_SYMS         (FRAG_SYMS),
    .SIGNED_INDICE_LEN (SIGNED_INDICE_LEN)
  ) u_extract (
    .buf_data  (w_rd_buf),
    .frag_idx  (frag_idx),
    .frag_data (w_frag)
  );

  // Fragment output register: reads the pre-release read buffer, holds data
  // between accepted requests, flags requests made with nothing to read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata     <= '0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      r_out_valid <= w_req_fire;
      r_out_err   <= req_valid && !buf_avail;
      if (w_req_fire) begin
        r_rdata <= w_frag;
      end
    end
  end

  a_occ_bound: assert property (@(posedge clk) disable iff (rst)
    r_occ <= OCC_W'(BUFFER_COUNT));
  a_no_full_write: assert property (@(posedge clk) disable iff (rst)
    w_wr_fire |-> (r_state[r_wr_ptr] != FM_FULL));
  a_valid_err_excl: assert property (@(posedge clk) disable iff (rst)
    !(r_out_valid && r_out_err));

endmodule

// File: doc/proj_fm_ring.md
Name: proj_fm_ring

Overview:
- N-way ring of fragment-memory buffers.
- A producer streams multi-symbol write beats into the current filling buffer under a valid/ready handshake.
- A consumer issues signed-index fragment requests against the oldest full buffer and receives zero-padded fragments with a registered, one-cycle latency.
- Generalises the two-buffer ping-pong FM: any buffer count, wide write beats, back-pressure instead of a silent hold, and an explicit release handshake. Sits between the FM extender write path and the ACMI fragment consumer.

Parameters:
- BUFFER_COUNT, 3, number of buffers in the ring (>=2).
- ENTRIES, 256, symbols per buffer (power of 2).
- DATA_BITS, 2, bits per symbol.
- WR_LANES, 4, symbols per write beat (power of 2, divides ENTRIES).
- FRAG_SYMS, 32, symbols per output fragment.
- SIGNED_INDICE_LEN, 10, width of the two's-complement fragment index (>= $clog2(ENTRIES)+1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  write beat valid.
- in_ready  out  1  ring can accept a beat.
- in_wdata  in  WR_LANES*DATA_BITS  beat; lane 0 in LSBs = lowest address.
- rel_valid  in  1  consumer releases the current read buffer.
- req_valid  in  1  fragment request.
- frag_idx  in  SIGNED_INDICE_LEN  signed start symbol index.
- buf_avail  out  1  at least one FULL buffer exists.
- out_valid  out  1  out_rdata valid (one-cycle pulse per accepted request).
- out_err  out  1  pulse: request issued while buf_avail=0.
- out_rdata  out  FRAG_SYMS*DATA_BITS  fragment; symbol 0 in LSBs.
- occupancy  out  $clog2(BUFFER_COUNT+1)  number of FULL buffers.

Behaviour:
- One clock, clk. Synchronous active-high reset rst.
- Reset values:
  - All buffers FREE; wr_ptr=0, rd_ptr=0, beat counter=0.
  - in_ready=1, buf_avail=0, out_valid=0, out_err=0, out_rdata=0, occupancy=0.
  - Buffer contents are not reset.
- Per-buffer state: FREE -> FILLING -> FULL -> FREE.
  - FREE->FILLING: wr_ptr selects the buffer and it is FREE.
  - FILLING->FULL: last beat written (beat counter = ENTRIES/WR_LANES-1). Counter wraps to 0 and wr_ptr advances mod BUFFER_COUNT.
  - FULL->FREE: rel_valid while buf_avail=1. rd_ptr advances mod BUFFER_COUNT.
- Write handshake:
  - A beat transfers when in_valid & in_ready.
  - The beat writes symbols [cnt*WR_LANES .. cnt*WR_LANES+WR_LANES-1] of buffer wr_ptr.
  - in_ready = buffer[wr_ptr] is not FULL. It is combinational from registered state only; no dependency on in_valid.
- Release:
  - rel_valid with buf_avail=0 is ignored.
  - A release in the same cycle as a completing write: both take effect and occupancy is unchanged.
  - A freed buffer is writable the next cycle.
- Fragment read:
  - A request is accepted when req_valid & buf_avail and reads buffer rd_ptr as of that cycle. A release in the same cycle applies after the read.
  - Symbol k (0..FRAG_SYMS-1) = buf[frag_idx+k] when 0 <= frag_idx+k < ENTRIES, else 0.
  - Negative frag_idx gives leading zeros; a tail past ENTRIES gives trailing zeros. All index math is signed at SIGNED_INDICE_LEN+1 bits with no wrap.
  - out_rdata and out_valid are registered: latency 1.
  - out_rdata holds its value until the next accepted request.
  - A request with buf_avail=0 produces out_err=1 next cycle, out_valid=0, and out_rdata unchanged.
- Writes into a FILLING buffer never alias the read buffer (the states are disjoint), so there is no read/write hazard.
- Reset mid-operation: all in-flight beats are lost and partial buffers are discarded; state returns to the reset values in the next cycle.
- Assertions:
  - occupancy <= BUFFER_COUNT.
  - No write to a FULL buffer.
  - out_valid and out_err are never both 1.

Decomposition:
- Add to proj_pkg:
  - FM_RING_BUFFER_COUNT, FM_WR_LANES, FM_FRAG_SYMS.
  - typedef enum fm_buf_state_e {FM_FREE, FM_FILLING, FM_FULL}.
- Reuse the existing FM_DATA_BITS and SIGNED_INDICE_LEN from proj_pkg.
- One sub-module, proj_fm_frag_extract: combinational signed-window zero-padded extraction from one buffer. It is instantiated once, fed by a rd_ptr-selected mux; the output register lives in the top.

Test Plan:
1. Reset; stream 64 beats with symbol value = addr mod 4; req frag_idx=0 -> next cycle out_valid=1, symbol k = k mod 4 for k=0..31; occupancy=1.
2. Same buffer, frag_idx=-5 -> symbols 0..4 = 0, symbol k = (k-5) mod 4 for k>=5; frag_idx=240 -> symbols 0..15 valid, 16..31 = 0; frag_idx=-40 -> all zero.
3. Fill 3 buffers without release -> in_ready=0 after beat 192 and occupancy=3; hold in_valid=1 for 10 cycles -> no write and contents unchanged; rel_valid -> in_ready=1 next cycle.
4. Request with occupancy=0 -> out_err=1 one cycle, out_valid=0, out_rdata unchanged.
5. Same cycle: last beat of buffer 1 + rel_valid of buffer 0 + req_valid -> fragment comes from buffer 0; occupancy stays 1; rd_ptr=1.
6. Assert rst mid-fill (beat 30) -> next cycle all outputs at reset values; refill starts at buffer 0 address 0.
